// File: rtl/btn_pkg.sv
// ------------------------------------------------------------------
// btn_pkg: shared encodings and 10 MHz timing defaults for btn_debounce4
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_e;

  // Auto-repeat runs in two phases: the long initial delay, then the short rate.
  typedef enum logic {
    PH_DELAY = 1'b0,
    PH_RATE  = 1'b1
  } rep_phase_e;

  localparam int DEF_NBTN         = 4;
  localparam int DEF_DEB_CYCLES   = 20000;    // 2 ms
  localparam int DEF_REPEAT_DELAY = 5000000;  // 500 ms
  localparam int DEF_REPEAT_RATE  = 1000000;  // 100 ms
  localparam int DEF_CNT_W        = 23;

endpackage

`default_nettype wire

// File: rtl/btn_debounce_ch.sv
// ------------------------------------------------------------------
// btn_debounce_ch: one button channel - 2-flop sync, debounce FSM, auto-repeat
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter bit REPEAT_EN    = 1'b1,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  btn_state_e       state_q, state_d;
  rep_phase_e       phase_q, phase_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  logic [CNT_W-1:0] rep_last;

  assign rep_last = (phase_q == PH_DELAY) ? DELAY_LAST : RATE_LAST;

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    state_d   = state_q;
    phase_d   = phase_q;
    deb_cnt_d = deb_cnt_q;
    rep_cnt_d = rep_cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;

    // With ena low everything but the synchroniser freezes and pulses stay 0.
    if (ena) begin
      case (state_q)
        RELEASED: begin
          if (sync2_q) begin
            state_d   = PRESS_CHK;
            deb_cnt_d = '0;
          end
        end
        PRESS_CHK: begin
          if (!sync2_q) begin
            state_d = RELEASED;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_d   = HELD;
            level_d   = 1'b1;
            press_d   = 1'b1;
            rep_cnt_d = '0;
            phase_d   = PH_DELAY;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!sync2_q) begin
            state_d   = RELEASE_CHK;
            deb_cnt_d = '0;
          end else if (REPEAT_EN) begin
            if (rep_cnt_q == rep_last) begin
              repeat_d  = 1'b1;
              rep_cnt_d = '0;
              phase_d   = PH_RATE;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
        end
        RELEASE_CHK: begin
          // rep_cnt is left alone here so a release glitch only delays the cadence.
          if (sync2_q) begin
            state_d = HELD;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_d   = RELEASED;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end
        default: state_d = RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= RELEASED;
      phase_q   <= PH_DELAY;
      deb_cnt_q <= '0;
      rep_cnt_q <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      phase_q   <= phase_d;
      deb_cnt_q <= deb_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule

`default_nettype wire

// File: rtl/btn_debounce4.sv
// ------------------------------------------------------------------
// btn_debounce4: NBTN independent button conditioners (level/press/release/repeat)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module btn_debounce4
  import btn_pkg::*;
#(
  parameter int NBTN         = DEF_NBTN,
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter bit REPEAT_EN    = 1'b1,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NBTN-1:0] btn_repeat
);

  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_repeat  (btn_repeat[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce4.sv
// ------------------------------------------------------------------
// tb_btn_debounce4: table vectors, directed corner cases and random stimulus vs a run-length model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_btn_debounce4;

  localparam int NBTN = 4;
  localparam int DEB  = 4;
  localparam int DLY  = 20;
  localparam int RATE = 8;
  localparam int CW   = 8;
  localparam int DEB1 = 1;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            ena   = 1'b0;
  logic [NBTN-1:0] btn_raw = '0;
  logic [NBTN-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic [NBTN-1:0] l1, p1, r1, q1;

  btn_debounce4 #(
    .NBTN(NBTN), .DEB_CYCLES(DEB), .REPEAT_EN(1'b1),
    .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  // Second instance: single-cycle debounce, auto-repeat disabled.
  btn_debounce4 #(
    .NBTN(NBTN), .DEB_CYCLES(DEB1), .REPEAT_EN(1'b0),
    .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .CNT_W(CW)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(btn_raw),
    .btn_level(l1), .btn_press(p1), .btn_release(r1), .btn_repeat(q1)
  );

  always #50 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_v(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a level change is accepted once the synchronised input has
  // disagreed with the accepted level for DEB+1 consecutive enabled edges.
  // Repeats fire when the number of undisturbed held edges since the press
  // equals DLY + n*RATE.
  logic [NBTN-1:0] m_s1, m_s2, m_level, m_press, m_release, m_repeat;
  int m_run [NBTN];
  int m_held[NBTN];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0;
    m_press = '0; m_release = '0; m_repeat = '0;
    for (int c = 0; c < NBTN; c++) begin
      m_run[c]  = 0;
      m_held[c] = 0;
    end
  endtask

  task automatic model_step(input logic [NBTN-1:0] raw, input logic en);
    m_press = '0; m_release = '0; m_repeat = '0;
    if (en) begin
      for (int c = 0; c < NBTN; c++) begin
        if (m_s2[c] != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB + 1) begin
            m_level[c] = m_s2[c];
            m_run[c]   = 0;
            if (m_s2[c]) begin
              m_press[c] = 1'b1;
              m_held[c]  = 0;
            end else begin
              m_release[c] = 1'b1;
            end
          end
        end else if (m_run[c] != 0) begin
          m_run[c] = 0;
        end else if (m_level[c]) begin
          m_held[c]++;
          if (m_held[c] >= DLY && ((m_held[c] - DLY) % RATE) == 0) m_repeat[c] = 1'b1;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  // Called at a negedge: drive, let the edge happen, compare at the next negedge.
  task automatic tick(input logic [NBTN-1:0] raw, input logic en, input string tag);
    btn_raw = raw;
    ena     = en;
    @(posedge clk);
    model_step(raw, en);
    @(negedge clk);
    check_v(tag, {btn_level, btn_press, btn_release, btn_repeat},
                 {m_level, m_press, m_release, m_repeat});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, 1'b1, "model_idle");
  endtask

  typedef struct {
    logic [NBTN-1:0] raw;
    int              n;
    logic [NBTN-1:0] lvl, prs, rel, rep;
  } vec_t;
  vec_t tbl[$];

  int t_press, t_first, t_second, t_prev, t_rel, n_rep, n_rel, bad_gap, rep_after, lvl_drop, n_p1, n_q1;
  int dur[NBTN];
  logic [NBTN-1:0] rraw;
  logic            ren;

  initial begin
    // Bounce on channel 0, then clean press/release on channel 1.
    for (int i = 0; i < 8; i++) tbl.push_back('{(i % 2 == 0) ? 4'b0001 : 4'b0000, 1, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'b0000, 8,  4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'b0010, 6,  4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'b0010, 1,  4'h2, 4'h2, 4'h0, 4'h0});
    tbl.push_back('{4'b0010, 19, 4'h2, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'b0010, 1,  4'h2, 4'h0, 4'h0, 4'h2});  // 20 held cycles after the press
    tbl.push_back('{4'b0010, 3,  4'h2, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'b0000, 6,  4'h2, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'b0000, 1,  4'h0, 4'h0, 4'h2, 4'h0});
    tbl.push_back('{4'b0000, 3,  4'h0, 4'h0, 4'h0, 4'h0});

    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_v("reset_state", {btn_level, btn_press, btn_release, btn_repeat}, 16'h0000);
    rst_n = 1'b1;
    idle(4);

    // ---------------- table vectors ----------------
    for (int e = 0; e < tbl.size(); e++) begin
      for (int j = 0; j < tbl[e].n; j++) begin
        tick(tbl[e].raw, 1'b1, "model_tbl");
        check_v($sformatf("tbl[%0d]", e), {btn_level, btn_press, btn_release, btn_repeat},
                {tbl[e].lvl, tbl[e].prs, tbl[e].rel, tbl[e].rep});
      end
    end
    idle(4);

    // ---------------- auto-repeat, channel 2 ----------------
    t_press = -1; t_first = -1; t_prev = -1; t_rel = -1; n_rep = 0; bad_gap = 0; rep_after = 0;
    for (int i = 0; i < 80; i++) begin
      tick((i < 60) ? 4'b0100 : 4'b0000, 1'b1, "model_rep");
      if (btn_press[2]) t_press = i;
      if (btn_repeat[2]) begin
        if (t_rel >= 0) rep_after++;
        if (n_rep == 0) t_first = i;
        else if (i - t_prev != RATE) bad_gap++;
        t_prev = i;
        n_rep++;
      end
      if (btn_release[2]) t_rel = i;
    end
    check_i("rep_press_time", t_press, DEB + 2);
    check_i("rep_first_delay", t_first - t_press, DLY);
    check_i("rep_gap_errors", bad_gap, 0);
    // Last held-high edge is one cycle after raw falls (synchroniser delay).
    check_i("rep_count", n_rep, (60 + 1 - (DEB + 2) - DLY) / RATE + 1);
    check_i("rep_release_time", t_rel, 60 + DEB + 2);
    check_i("rep_after_release", rep_after, 0);
    idle(4);

    // ---------------- release glitch, channel 3 ----------------
    t_press = -1; t_first = -1; t_second = -1; t_rel = -1; n_rel = 0; lvl_drop = 0;
    for (int i = 0; i < 66; i++) begin
      tick((i < 10 || (i >= 12 && i < 52)) ? 4'b1000 : 4'b0000, 1'b1, "model_glitch");
      if (btn_press[3]) t_press = i;
      if (btn_repeat[3]) begin
        if (t_first < 0) t_first = i;
        else if (t_second < 0) t_second = i;
      end
      if (btn_release[3]) begin
        t_rel = i;
        if (i < 52) n_rel++;
      end
      if (i > 6 && i < 52 && !btn_level[3]) lvl_drop++;
    end
    check_i("glitch_no_release", n_rel, 0);
    check_i("glitch_level_held", lvl_drop, 0);
    // Two low synchronised edges plus the edge that returns to held are not counted.
    check_i("glitch_first_repeat", t_first - t_press, DLY + 3);
    check_i("glitch_second_repeat", t_second - t_first, RATE);
    check_i("glitch_final_release", t_rel, 52 + DEB + 2);
    idle(4);

    // ---------------- DEB_CYCLES=1, repeat disabled (second instance) ----------------
    n_p1 = 0;
    for (int i = 0; i < 8; i++) begin
      tick((i == 0) ? 4'b0001 : 4'b0000, 1'b1, "model_deb1a");
      if (p1[0] || l1[0]) n_p1++;
    end
    check_i("deb1_single_cycle_rejected", n_p1, 0);
    t_press = -1; t_rel = -1; n_p1 = 0; n_q1 = 0;
    for (int i = 0; i < 38; i++) begin
      tick((i < 30) ? 4'b0001 : 4'b0000, 1'b1, "model_deb1b");
      if (p1[0]) begin t_press = i; n_p1++; end
      if (r1[0]) t_rel = i;
      if (q1 != '0) n_q1++;
    end
    check_i("deb1_press_time", t_press, DEB1 + 2);
    check_i("deb1_press_count", n_p1, 1);
    check_i("deb1_no_repeat", n_q1, 0);
    check_i("deb1_release_time", t_rel, 30 + DEB1 + 2);
    idle(4);

    // ---------------- asynchronous reset mid-press, channel 0 ----------------
    for (int i = 0; i < 10; i++) tick(4'b0001, 1'b1, "model_prerst");
    check_v("prerst_level", {12'h0, btn_level}, 16'h0001);
    #20;
    rst_n = 1'b0;
    #1;
    check_v("async_reset_outputs", {btn_level, btn_press, btn_release, btn_repeat}, 16'h0000);
    model_reset();
    @(negedge clk);
    check_v("reset_hold_outputs", {btn_level, btn_press, btn_release, btn_repeat}, 16'h0000);
    rst_n = 1'b1;
    t_press = -1; n_rel = 0;
    for (int i = 0; i < 10; i++) begin
      tick(4'b0001, 1'b1, "model_postrst");
      if (btn_press[0]) t_press = i;
      if (btn_release != '0) n_rel++;
    end
    check_i("postrst_press_time", t_press, DEB + 2);
    check_i("postrst_no_release", n_rel, 0);
    idle(10);

    // ---------------- simultaneous press, then ena=0 ----------------
    for (int i = 0; i < 8; i++) begin
      tick(4'b1111, 1'b1, "model_sim");
      if (i == DEB + 2) check_v("sim_press_all", {12'h0, btn_press}, 16'h000F);
    end
    for (int i = 0; i < 10; i++) begin
      tick(4'b0000, 1'b0, "model_ena0");
      check_v("ena0_hold", {btn_level, btn_press, btn_release, btn_repeat}, 16'hF000);
    end
    t_rel = -1;
    for (int i = 0; i < 10; i++) begin
      tick(4'b0000, 1'b1, "model_ena1");
      if (btn_release == 4'hF && t_rel < 0) t_rel = i;
    end
    check_i("ena_resume_release", t_rel, DEB);

    // ---------------- random stimulus ----------------
    rraw = '0;
    for (int c = 0; c < NBTN; c++) dur[c] = $urandom_range(1, 14);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NBTN; c++) begin
        dur[c]--;
        if (dur[c] <= 0) begin
          rraw[c] = ~rraw[c];
          dur[c]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
        end
      end
      ren = ($urandom_range(0, 9) != 0);
      tick(rraw, ren, "model_rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
